vram_rd_arbiter: RTL and testbench

Time-multiplexes the single VRAM block-RAM read port between two requesters: the display fetch pipeline (character/attribute fetch) and the host interface. Fixed alternating slot schedule, so display fetch timing is deterministic. Host reads use a req/busy/valid handshake. Sits between the pixel-generation fetch logic, the host bus interface and the VRAM read port. VRAM read latency is 1 clock: the address is presented in cycle N and data appears on memRdData in cycle N+1.

---
 rtl/vram_rd_arbiter.sv | 116 +++++++++++
 tb/tb_vram_rd_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_rd_arbiter.sv
// Shares the single VRAM read port between display fetch (slot 0) and host reads (slot 1).
// Build option VRAM_ARB_SLOT_STEAL_EN: a pending host read may use an idle display slot.
module vram_rd_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] dispAddr,
    input  logic              dispReq,
    output logic [DATA_W-1:0] dispData,
    output logic              dispValid,
    output logic              slot,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic              hostRdReq,
    output logic              hostBusy,
    output logic [DATA_W-1:0] hostRdData,
    output logic              hostRdValid,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRdEn,
    input  logic [DATA_W-1:0] memRdData
);

    // Host read FSM
    // state  | meaning
    // H_IDLE | no host read outstanding, requests accepted
    // H_PEND | request latched, waiting for a host-usable slot
    // H_INFL | read issued last cycle, memRdData carries the host byte now
    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_PEND = 2'd1,
        H_INFL = 2'd2
    } host_state_t;

    host_state_t       r_hst;
    host_state_t       w_hst_nxt;

    logic              r_slot;
    logic [ADDR_W-1:0] r_host_addr;
    logic              r_disp_tag;
    logic              r_disp_vld;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_host_vld;
    logic [DATA_W-1:0] r_host_data;

    logic              w_steal;
    logic              w_host_issue;
    logic              w_disp_issue;
    logic              w_host_accept;

`ifdef VRAM_ARB_SLOT_STEAL_EN
    assign w_steal = ~r_slot & ~dispReq & (r_hst == H_PEND);
`else
    assign w_steal = 1'b0;
`endif

    assign w_disp_issue  = ~r_slot & dispReq;
    assign w_host_issue  = (r_slot & (r_hst == H_PEND)) | w_steal;
    assign w_host_accept = (r_hst == H_IDLE) & hostRdReq;

    assign memRdEn = w_disp_issue | w_host_issue;
    assign memAddr = (r_slot | w_steal) ? r_host_addr : dispAddr;

    always_comb begin
        w_hst_nxt = r_hst;
        case (r_hst)
            H_IDLE:  if (hostRdReq) w_hst_nxt = H_PEND;
            H_PEND:  if (w_host_issue) w_hst_nxt = H_INFL;
            H_INFL:  w_hst_nxt = H_IDLE;
            default: w_hst_nxt = H_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_hst <= H_IDLE;
        end else begin
            r_hst <= w_hst_nxt;
        end
    end

    // Tags are cleared by reset, so data returning right after reset is never captured.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_slot      <= 1'b0;
            r_host_addr <= '0;
            r_disp_tag  <= 1'b0;
            r_disp_vld  <= 1'b0;
            r_disp_data <= '0;
            r_host_vld  <= 1'b0;
            r_host_data <= '0;
        end else begin
            r_slot     <= ~r_slot;
            r_disp_tag <= w_disp_issue;
            r_disp_vld <= r_disp_tag;
            r_host_vld <= (r_hst == H_INFL);
            if (r_disp_tag) begin
                r_disp_data <= memRdData;
            end
            if (r_hst == H_INFL) begin
                r_host_data <= memRdData;
            end
            if (w_host_accept) begin
                r_host_addr <= hostAddr;
            end
        end
    end

    assign slot        = r_slot;
    assign dispData    = r_disp_data;
    assign dispValid   = r_disp_vld;
    assign hostBusy    = (r_hst != H_IDLE);
    assign hostRdData  = r_host_data;
    assign hostRdValid = r_host_vld;

endmodule

// File: tb/tb_vram_rd_arbiter.sv
// Directed and random checks of vram_rd_arbiter against a cycle-level reference model.
// VRAM model returns addr[7:0] one cycle after a read is issued.
module tb_vram_rd_arbiter;

`ifdef VRAM_ARB_SLOT_STEAL_EN
    localparam bit STEAL         = 1'b1;
    localparam int EXP_STEAL_LAT = 3;
`else
    localparam bit STEAL         = 1'b0;
    localparam int EXP_STEAL_LAT = 4;
`endif

    logic        clk;
    logic        nrst;
    logic [12:0] dispAddr;
    logic        dispReq;
    logic [7:0]  dispData;
    logic        dispValid;
    logic        slot;
    logic [12:0] hostAddr;
    logic        hostRdReq;
    logic        hostBusy;
    logic [7:0]  hostRdData;
    logic        hostRdValid;
    logic [12:0] memAddr;
    logic        memRdEn;
    logic [7:0]  memRdData;

    vram_rd_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk(clk), .nrst(nrst),
        .dispAddr(dispAddr), .dispReq(dispReq), .dispData(dispData), .dispValid(dispValid),
        .slot(slot),
        .hostAddr(hostAddr), .hostRdReq(hostRdReq), .hostBusy(hostBusy),
        .hostRdData(hostRdData), .hostRdValid(hostRdValid),
        .memAddr(memAddr), .memRdEn(memRdEn), .memRdData(memRdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM: data for an issued address appears in the next cycle; 0xEE when nothing was issued
    always @(posedge clk) memRdData <= memRdEn ? memAddr[7:0] : 8'hEE;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic        s_slot, s_memen, s_dvld, s_hvld, s_hbusy;
    logic [12:0] s_maddr;
    logic [7:0]  s_ddata, s_hdata;

    logic        m_slot, m_busy, m_issued;
    logic [12:0] m_haddr;
    logic [7:0]  m_ddata, m_hdata, m_d_val, m_h_val;
    int          m_d_due, m_h_due;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_slot   = 1'b0;
        m_busy   = 1'b0;
        m_issued = 1'b0;
        m_haddr  = '0;
        m_ddata  = '0;
        m_hdata  = '0;
        m_d_val  = '0;
        m_h_val  = '0;
        m_d_due  = -1;
        m_h_due  = -1;
    endtask

    task automatic do_reset(input int n);
        nrst      = 1'b0;
        dispReq   = 1'b0;
        dispAddr  = '0;
        hostRdReq = 1'b0;
        hostAddr  = '0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_slot",     32'(slot),        0);
        chk("rst_busy",     32'(hostBusy),    0);
        chk("rst_hvld",     32'(hostRdValid), 0);
        chk("rst_dvld",     32'(dispValid),   0);
        chk("rst_ddata",    32'(dispData),    0);
        chk("rst_hdata",    32'(hostRdData),  0);
        chk("rst_memen",    32'(memRdEn),     0);
        chk("rst_memaddr",  32'(memAddr),     0);
        nrst = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, sample, compare with model, advance model and clock.
    task automatic run_cycle(input logic dreq, input logic [12:0] daddr,
                             input logic hreq, input logic [12:0] haddr);
        logic        e_hiss;
        logic        e_en;
        logic [12:0] e_addr;
        dispReq   = dreq;
        dispAddr  = daddr;
        hostRdReq = hreq;
        hostAddr  = haddr;
        #2;
        s_slot  = slot;
        s_memen = memRdEn;
        s_maddr = memAddr;
        s_dvld  = dispValid;
        s_ddata = dispData;
        s_hvld  = hostRdValid;
        s_hdata = hostRdData;
        s_hbusy = hostBusy;

        if (m_d_due == cyc) m_ddata = m_d_val;
        if (m_h_due == cyc) begin
            m_hdata = m_h_val;
            m_busy  = 1'b0;
        end
        e_hiss = m_busy && !m_issued && (m_slot || (STEAL && !dreq));
        e_en   = (!m_slot && dreq) || e_hiss;
        e_addr = (m_slot || e_hiss) ? m_haddr : daddr;

        chk($sformatf("slot@%0d", cyc),     32'(s_slot),  32'(m_slot));
        chk($sformatf("memRdEn@%0d", cyc),  32'(s_memen), 32'(e_en));
        chk($sformatf("memAddr@%0d", cyc),  32'(s_maddr), 32'(e_addr));
        chk($sformatf("dispValid@%0d", cyc), 32'(s_dvld), 32'(m_d_due == cyc));
        chk($sformatf("dispData@%0d", cyc), 32'(s_ddata), 32'(m_ddata));
        chk($sformatf("hostBusy@%0d", cyc), 32'(s_hbusy), 32'(m_busy));
        chk($sformatf("hostRdValid@%0d", cyc), 32'(s_hvld), 32'(m_h_due == cyc));
        chk($sformatf("hostRdData@%0d", cyc), 32'(s_hdata), 32'(m_hdata));

        if (!m_slot && dreq) begin
            m_d_due = cyc + 2;
            m_d_val = daddr[7:0];
        end
        if (e_hiss) begin
            m_issued = 1'b1;
            m_h_due  = cyc + 2;
            m_h_val  = m_haddr[7:0];
        end
        if (hreq && !m_busy) begin
            m_busy   = 1'b1;
            m_issued = 1'b0;
            m_haddr  = haddr;
        end
        m_slot = !m_slot;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        bit found;
        model_reset();
        do_reset(2);

        // Display-only fetch at 0x0005
        run_cycle(1, 13'h0005, 0, 0);
        chk("d_en_slot0", 32'(s_memen), 1);
        chk("d_addr", 32'(s_maddr), 32'h0005);
        run_cycle(1, 13'h0005, 0, 0);
        chk("d_en_slot1", 32'(s_memen), 0);
        chk("d_vld_early", 32'(s_dvld), 0);
        run_cycle(1, 13'h0005, 0, 0);
        chk("d_vld_first", 32'(s_dvld), 1);
        chk("d_data_first", 32'(s_ddata), 32'h05);
        run_cycle(1, 13'h0005, 0, 0);
        chk("d_vld_gap", 32'(s_dvld), 0);
        run_cycle(1, 13'h0005, 0, 0);
        chk("d_vld_second", 32'(s_dvld), 1);

        // Host best case, ignored request while busy, re-request in valid cycle (worst case)
        for (int i = 0; i < 4 && m_slot != 1'b0; i++) run_cycle(1, 13'h0005, 0, 0);
        run_cycle(1, 13'h0005, 1, 13'h12C0);
        chk("h_idle_at_accept", 32'(s_hbusy), 0);
        run_cycle(1, 13'h0005, 1, 13'h0001);
        chk("h_busy", 32'(s_hbusy), 1);
        chk("h_issue_en", 32'(s_memen), 1);
        chk("h_issue_addr", 32'(s_maddr), 32'h12C0);
        run_cycle(1, 13'h0005, 1, 13'h0001);
        chk("h_vld_early", 32'(s_hvld), 0);
        chk("d_between_vld", 32'(s_dvld), 1);
        chk("d_between_data", 32'(s_ddata), 32'h05);
        run_cycle(1, 13'h0005, 1, 13'h0123);
        chk("h_vld_best", 32'(s_hvld), 1);
        chk("h_data_best", 32'(s_hdata), 32'hC0);
        chk("h_busy_clr", 32'(s_hbusy), 0);
        run_cycle(1, 13'h00AB, 0, 0);
        chk("h2_busy", 32'(s_hbusy), 1);
        chk("h2_disp_en", 32'(s_memen), 1);
        chk("h2_disp_addr", 32'(s_maddr), 32'h00AB);
        run_cycle(1, 13'h00AB, 0, 0);
        chk("h2_issue_addr", 32'(s_maddr), 32'h0123);
        run_cycle(1, 13'h00AB, 0, 0);
        chk("h2_vld_early", 32'(s_hvld), 0);
        chk("h2_disp_data", 32'(s_ddata), 32'hAB);
        run_cycle(1, 13'h00AB, 0, 0);
        chk("h2_vld_worst", 32'(s_hvld), 1);
        chk("h2_data_worst", 32'(s_hdata), 32'h23);

        // Reset one cycle after host issue drops the read
        for (int i = 0; i < 4 && m_slot != 1'b0; i++) run_cycle(0, 0, 0, 0);
        run_cycle(0, 0, 1, 13'h01A5);
        run_cycle(0, 0, 0, 0);
        chk("rm_issue_en", 32'(s_memen), 1);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 0, 0, 0);
            chk("rm_no_hvld", 32'(s_hvld), 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 1000; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 13'($urandom),
                      1'($urandom_range(0, 1)), 13'($urandom));
        end

        // Host request accepted in a slot-1 cycle with the display idle
        for (int i = 0; i < 8 && (m_busy || m_slot != 1'b1); i++) run_cycle(0, 0, 0, 0);
        run_cycle(0, 0, 1, 13'h0777);
        lat   = 0;
        found = 1'b0;
        for (int i = 1; i <= 8 && !found; i++) begin
            run_cycle(0, 0, 0, 0);
            if (s_hvld) begin
                found = 1'b1;
                lat   = i;
            end
        end
        chk("idle_disp_host_lat", 32'(lat), 32'(EXP_STEAL_LAT));
        chk("idle_disp_host_data", 32'(s_hdata), 32'h77);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
